// File: rtl/alu_pkg.sv
// Shared ALU control encoding, used by the ALU decoder and the execute-stage ALU.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD = 3'b000;
  localparam alu_ctrl_t ALU_SUB = 3'b001;
  localparam alu_ctrl_t ALU_AND = 3'b010;
  localparam alu_ctrl_t ALU_OR  = 3'b011;
  localparam alu_ctrl_t ALU_SLT = 3'b101;

  function automatic logic alu_is_legal(input alu_ctrl_t ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_AND) ||
           (ctrl == ALU_OR)  || (ctrl == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one control code and two operands in,
// result plus signed-overflow and illegal-code flags out.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_CTRL_W-1:0] control,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic [WIDTH-1:0]      result,
  output logic                  overflow,
  output logic                  illegal
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic             slt_bit;

  assign sum  = a + b;
  assign diff = a - b;

  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Sign of the difference corrected by overflow gives a full-range signed compare.
  assign slt_bit = diff[WIDTH-1] ^ ovf_sub;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (control)
      ALU_ADD: begin
        result   = sum;
        overflow = ovf_add;
      end
      ALU_SUB: begin
        result   = diff;
        overflow = ovf_sub;
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_bit};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage execute-stage ALU: S1 registers the operation, S2 registers the
// computed result and flags. Valid/ready flow control on both sides.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  overflow,
  output logic                  illegal
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holds its payload stable while valid && !ready, and ready
  // may depend combinationally on the consumer's ready (in_ready follows out_ready).
  logic                  s1_valid;
  logic [ALU_CTRL_W-1:0] s1_ctrl;
  logic [WIDTH-1:0]      s1_a;
  logic [WIDTH-1:0]      s1_b;
  logic                  s2_valid;

  logic                  s2_adv;
  logic                  s1_adv;
  logic                  accept;

  logic [WIDTH-1:0]      core_result;
  logic                  core_overflow;
  logic                  core_illegal;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_adv;
  assign in_ready  = !s1_valid || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      // When in_ready is high S1 is either empty or moving into S2 this edge.
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_ctrl <= alu_control;
        s1_a    <= src_a;
        s1_b    <= src_b;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .control  (s1_ctrl),
    .a        (s1_a),
    .b        (s1_b),
    .result   (core_result),
    .overflow (core_overflow),
    .illegal  (core_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      // Payload only loads on a real refill, so a drained S2 keeps its last value.
      if (s1_adv) begin
        result   <= core_result;
        zero     <= (core_result == '0);
        overflow <= core_overflow;
        illegal  <= core_illegal;
      end
    end
  end

endmodule
